// File: rtl/fifo_wr_arbiter_if.sv
// Bus between four producers, the write arbiter and the fifo write port.
// Handshake: producer i holds req[i] and its data slice stable until the
// rising edge where req[i] & ack[i] is 1; that word transfers on that edge.
// ack is combinational and at most one-hot.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic [3:0]              req;
  logic [4*DATA_WIDTH-1:0] req_data;
  logic [3:0]              ack;
  logic [CNT_WIDTH-1:0]    fifo_data_count;
  logic                    fifo_wr_err;
  logic                    fifo_wr_en;
  logic [DATA_WIDTH-1:0]   fifo_din;

  modport master (
    output req, req_data, fifo_data_count, fifo_wr_err,
    input  ack, fifo_wr_en, fifo_din
  );

  modport slave (
    input  req, req_data, fifo_data_count, fifo_wr_err,
    output ack, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port among four producers.
// Never issues a write the fifo cannot absorb; the write is registered.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic             clk,
  input  logic             reset,
  fifo_wr_arbiter_if.slave bus,
  output logic             busy,
  output logic [1:0]       owner,
  output logic [7:0]       err_cnt,
  output logic             state_dbg,
  output logic [1:0]       rr_ptr_dbg
);
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state, state_n;
  logic [1:0]            rr_ptr, rr_ptr_n, owner_n, winner, grant_idx;
  logic [3:0]            beat_cnt, beat_cnt_n;
  logic [3:0]            ack_c;
  logic [CNT_WIDTH:0]    occupancy;
  logic                  room, xfer;
  logic [DATA_WIDTH-1:0] grant_data;

  // The write already in flight counts as occupied; pending reads are ignored.
  assign occupancy = {1'b0, bus.fifo_data_count} + {{CNT_WIDTH{1'b0}}, bus.fifo_wr_en};
  assign room      = occupancy < (CNT_WIDTH+1)'(DEPTH);

  // Lowest rotated offset from rr_ptr wins, so scan from the far end down.
  always_comb begin
    winner = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[rr_ptr + 2'(k)]) winner = rr_ptr + 2'(k);
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    ack_c      = '0;
    grant_idx  = owner;
    case (state)
      IDLE: begin
        grant_idx = winner;
        if (room && (bus.req != 4'b0000)) begin
          ack_c[winner] = 1'b1;
          owner_n       = winner;
          if (BURST_LEN == 1) begin
            rr_ptr_n = winner + 2'd1;
          end else begin
            state_n    = BURST;
            beat_cnt_n = 4'd1;
          end
        end
      end
      BURST: begin
        if (!bus.req[owner]) begin
          state_n  = IDLE;
          rr_ptr_n = owner + 2'd1;
        end else if (room) begin
          ack_c[owner] = 1'b1;
          beat_cnt_n   = beat_cnt + 4'd1;
          if (({1'b0, beat_cnt} + 5'd1) == 5'(BURST_LEN)) begin
            state_n  = IDLE;
            rr_ptr_n = owner + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_idx == 2'(i)) grant_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ack implies req, so any ack bit is a transfer on the next edge.
  assign xfer    = |ack_c;
  assign bus.ack = reset ? 4'b0000 : ack_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= 2'd0;
      owner          <= 2'd0;
      beat_cnt       <= 4'd0;
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_din   <= '0;
      err_cnt        <= 8'd0;
    end else begin
      state          <= state_n;
      rr_ptr         <= rr_ptr_n;
      owner          <= owner_n;
      beat_cnt       <= beat_cnt_n;
      bus.fifo_wr_en <= xfer;
      if (xfer) bus.fifo_din <= grant_data;
      if (bus.fifo_wr_err && (err_cnt != 8'hff)) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign busy       = (state == BURST);
  assign state_dbg  = (state == BURST);
  assign rr_ptr_dbg = rr_ptr;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed producer traffic on a BURST_LEN=4 and a
// BURST_LEN=1 instance, writes checked against a queue of hand-computed words.
module tb_fifo_wr_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic [3:0] req_v = '0;
  logic [4*DW-1:0] req_data_v = '0;
  logic [3:0] count_v = '0;
  logic err_v = 1'b0;
  logic [3:0] ack_v;

  logic busy0, busy1, st0, st1;
  logic [1:0] owner0, owner1, rr0, rr1;
  logic [7:0] err_cnt0, err_cnt1;

  int rem[4] = '{0, 0, 0, 0};
  int idx[4] = '{0, 0, 0, 0};
  logic [DW-1:0] base[4];
  logic [3:0] xfer_s;

  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) if0 ();
  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) if1 ();

  assign if0.req             = sel ? 4'b0000 : req_v;
  assign if1.req             = sel ? req_v : 4'b0000;
  assign if0.req_data        = req_data_v;
  assign if1.req_data        = req_data_v;
  assign if0.fifo_data_count = count_v;
  assign if1.fifo_data_count = count_v;
  assign if0.fifo_wr_err     = err_v;
  assign if1.fifo_wr_err     = err_v;
  assign ack_v               = sel ? if1.ack : if0.ack;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(8), .CNT_WIDTH(4), .BURST_LEN(4)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .busy(busy0), .owner(owner0),
    .err_cnt(err_cnt0), .state_dbg(st0), .rr_ptr_dbg(rr0)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(8), .CNT_WIDTH(4), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .busy(busy1), .owner(owner1),
    .err_cnt(err_cnt1), .state_dbg(st1), .rr_ptr_dbg(rr1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_v[i] = (rem[i] != 0);
      req_data_v[i*DW +: DW] = base[i] + DW'(idx[i]);
    end
  endtask

  task automatic load(input int p, input logic [DW-1:0] b, input int n);
    base[p] = b;
    idx[p]  = 0;
    rem[p]  = n;
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (((exp_q0.size() + exp_q1.size()) != 0) && (n < 100)) begin
      step();
      n++;
    end
    chk("drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
  endtask

  // Producers: a word is consumed when req & ack was seen before the edge.
  initial begin
    for (int i = 0; i < 4; i++) base[i] = '0;
    drive();
    forever begin
      @(negedge clk);
      xfer_s = req_v & ack_v;
      if (ack_v != 4'b0000) chk("ack_onehot", 64'($onehot(ack_v)), 64'd1);
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (xfer_s[i]) begin
          idx[i]++;
          rem[i]--;
        end
      end
      drive();
    end
  end

  // ---------------- scoreboard monitors ----------------
  initial begin
    logic [33:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (if0.fifo_wr_en) begin
        if (exp_q0.size() == 0) begin
          chk("wr0_unexpected", {30'd0, owner0, if0.fifo_din}, 64'd0 - 64'd1);
        end else begin
          e = exp_q0.pop_front();
          chk("wr0_word", {30'd0, owner0, if0.fifo_din}, {30'd0, e});
        end
      end
      if (if1.fifo_wr_en) begin
        if (exp_q1.size() == 0) begin
          chk("wr1_unexpected", {30'd0, owner1, if1.fifo_din}, 64'd0 - 64'd1);
        end else begin
          e = exp_q1.pop_front();
          chk("wr1_word", {30'd0, owner1, if1.fifo_din}, {30'd0, e});
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int streak;

    // Reset state, with every producer requesting.
    step();
    step();
    for (int i = 0; i < 4; i++) load(i, 32'h0, 1);
    drive();
    #1;
    chk("rst_ack", 64'(ack_v), 64'd0);
    chk("rst_wr_en", 64'(if0.fifo_wr_en), 64'd0);
    chk("rst_din", 64'(if0.fifo_din), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_owner", 64'(owner0), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt0), 64'd0);
    chk("rst_rr_ptr", 64'(rr0), 64'd0);
    for (int i = 0; i < 4; i++) rem[i] = 0;
    drive();
    reset = 1'b0;
    step();

    // Single requester.
    load(0, 32'hffff0000, 1);
    drive();
    exp_q0.push_back({2'd0, 32'hffff0000});
    #1;
    chk("t1_ack", 64'(ack_v), 64'h1);
    step();
    #1;
    chk("t1_wr_en", 64'(if0.fifo_wr_en), 64'd1);
    chk("t1_din", 64'(if0.fifo_din), 64'hffff0000);
    chk("t1_busy", 64'(busy0), 64'd1);
    chk("t1_owner", 64'(owner0), 64'd0);
    step();
    #1;
    chk("t1_release_busy", 64'(busy0), 64'd0);
    chk("t1_rr_ptr", 64'(rr0), 64'd1);

    // Burst limit: alternating bursts of four, no bubble.
    pulse_reset();
    load(0, 32'h0000ffff, 8);
    load(1, 32'h00ff00ff, 8);
    drive();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) exp_q0.push_back({2'd0, 32'h0000ffff + 32'(b*4 + k)});
      for (int k = 0; k < 4; k++) exp_q0.push_back({2'd1, 32'h00ff00ff + 32'(b*4 + k)});
    end
    step();
    streak = 0;
    repeat (16) begin
      #1;
      if (if0.fifo_wr_en) streak++;
      step();
    end
    chk("t2_streak", 64'(streak), 64'd16);
    chk("t2_busy", 64'(busy0), 64'd0);
    chk("t2_rr_ptr", 64'(rr0), 64'd2);
    wait_drain();

    // Early release: bubble, then req2 beats a re-asserted req0.
    pulse_reset();
    load(0, 32'h10000000, 2);
    load(2, 32'h20000000, 3);
    drive();
    exp_q0.push_back({2'd0, 32'h10000000});
    exp_q0.push_back({2'd0, 32'h10000001});
    for (int k = 0; k < 3; k++) exp_q0.push_back({2'd2, 32'h20000000 + 32'(k)});
    exp_q0.push_back({2'd0, 32'h10000010});
    step();
    step();
    #1;
    chk("t3_bubble_ack", 64'(ack_v), 64'd0);
    chk("t3_bubble_busy", 64'(busy0), 64'd1);
    step();
    load(0, 32'h10000010, 1);
    drive();
    #1;
    chk("t3_rr_ptr", 64'(rr0), 64'd1);
    chk("t3_winner", 64'(ack_v), 64'h4);
    wait_drain();

    // Full guard.
    pulse_reset();
    count_v = 4'd7;
    load(1, 32'h30000000, 3);
    drive();
    for (int k = 0; k < 3; k++) exp_q0.push_back({2'd1, 32'h30000000 + 32'(k)});
    #1;
    chk("t4_ack_room", 64'(ack_v), 64'h2);
    step();
    #1;
    chk("t4_inflight_ack", 64'(ack_v), 64'd0);
    count_v = 4'd8;
    step();
    step();
    #1;
    chk("t4_full_wr_en", 64'(if0.fifo_wr_en), 64'd0);
    chk("t4_full_ack", 64'(ack_v), 64'd0);
    chk("t4_full_busy", 64'(busy0), 64'd1);
    chk("t4_full_owner", 64'(owner0), 64'd1);
    step();
    count_v = 4'd6;
    #1;
    chk("t4_resume", 64'(ack_v), 64'h2);
    wait_drain();
    count_v = 4'd0;
    chk("t4_err_cnt", 64'(err_cnt0), 64'd0);

    // Error counter counts and saturates.
    err_v = 1'b1;
    repeat (3) step();
    #1;
    chk("err_cnt_3", 64'(err_cnt0), 64'd3);
    repeat (260) step();
    #1;
    chk("err_cnt_sat", 64'(err_cnt0), 64'd255);
    err_v = 1'b0;

    // Fairness wrap on the single-beat instance.
    sel = 1'b1;
    pulse_reset();
    load(2, 32'h50000000, 1);
    drive();
    exp_q1.push_back({2'd2, 32'h50000000});
    step();
    step();
    load(0, 32'h60000000, 2);
    load(3, 32'h70000000, 2);
    drive();
    exp_q1.push_back({2'd3, 32'h70000000});
    exp_q1.push_back({2'd0, 32'h60000000});
    exp_q1.push_back({2'd3, 32'h70000001});
    exp_q1.push_back({2'd0, 32'h60000001});
    #1;
    chk("t5_rr_ptr", 64'(rr1), 64'd3);
    chk("t5_first_ack", 64'(ack_v), 64'h8);
    step();
    #1;
    chk("t5_busy", 64'(busy1), 64'd0);
    wait_drain();
    sel = 1'b0;
    step();

    // Reset during the second beat of a burst.
    pulse_reset();
    load(0, 32'h80000000, 4);
    drive();
    exp_q0.push_back({2'd0, 32'h80000000});
    step();
    reset = 1'b1;
    #1;
    chk("t6_wr_en", 64'(if0.fifo_wr_en), 64'd0);
    chk("t6_busy", 64'(busy0), 64'd0);
    chk("t6_ack", 64'(ack_v), 64'd0);
    step();
    reset = 1'b0;
    load(1, 32'h90000000, 1);
    load(2, 32'ha0000000, 1);
    load(3, 32'hb0000000, 1);
    drive();
    for (int k = 1; k < 4; k++) exp_q0.push_back({2'd0, 32'h80000000 + 32'(k)});
    exp_q0.push_back({2'd1, 32'h90000000});
    exp_q0.push_back({2'd2, 32'ha0000000});
    exp_q0.push_back({2'd3, 32'hb0000000});
    #1;
    chk("t6_rr_ptr", 64'(rr0), 64'd0);
    chk("t6_first_ack", 64'(ack_v), 64'h1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets four producers share the single write port of the fifo block (wr_en/din/data_count/wr_err).
- Each producer has a valid/ready handshake (req/ack).
- The arbiter grants bursts of up to BURST_LEN words per owner and never issues a write the fifo cannot absorb.
- It sits between the producers and the fifo instance; it does not touch the fifo read port.

Parameters:
- DATA_WIDTH, 32, word width (must match the fifo din).
- DEPTH, 8, fifo capacity in words.
- CNT_WIDTH, 4, width of fifo data_count (must hold 0..DEPTH).
- BURST_LEN, 4, maximum consecutive words granted to one owner; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  req[i]: producer i has a word on its data slice.
- req_data  in  4*DATA_WIDTH  producer i data = req_data[i*DATA_WIDTH +: DATA_WIDTH]; held stable while req[i]=1 and ack[i]=0.
- ack  out  4  combinational; a word transfers on the rising edge where req[i]&ack[i]=1.
- fifo_data_count  in  CNT_WIDTH  fifo data_count.
- fifo_wr_err  in  1  fifo wr_err.
- fifo_wr_en  out  1  registered fifo wr_en.
- fifo_din  out  DATA_WIDTH  registered fifo din.
- busy  out  1  state==BURST.
- owner  out  2  current/last owner index.
- err_cnt  out  8  saturating count of fifo_wr_err cycles.

Behaviour:
- Reset (async, reset=1):
  - State IDLE; rr_ptr=0; owner=0; beat_cnt=0.
  - fifo_wr_en=0; fifo_din=0; err_cnt=0; busy=0.
  - ack=0 while reset is high.
- Room:
  - room = (fifo_data_count + fifo_wr_en) < DEPTH.
  - Compute with CNT_WIDTH+1 bits so the sum cannot wrap.
  - The in-flight registered write counts as occupied.
  - Reads freeing space are ignored, so the check is conservative.
- Winner:
  - winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Combinational; only meaningful when req != 0.
- IDLE:
  - ack[winner] = room & (req != 0); all other ack bits are 0.
  - On transfer: owner <= winner.
  - If BURST_LEN==1: stay IDLE, rr_ptr <= winner+1.
  - Otherwise: state <= BURST, beat_cnt <= 1.
- BURST:
  - ack[owner] = room & req[owner]; all other ack bits are 0.
  - On transfer: beat_cnt <= beat_cnt+1.
  - If beat_cnt+1 == BURST_LEN: state <= IDLE, rr_ptr <= owner+1.
  - If req[owner]=0 in any BURST cycle: state <= IDLE, rr_ptr <= owner+1. This costs a 1-cycle bubble.
  - If room=0: stay in BURST, ack=0, owner kept. No timeout.
- Write path:
  - On the edge where a transfer occurs, fifo_wr_en <= 1 and fifo_din <= the transferring word.
  - Otherwise fifo_wr_en <= 0 and fifo_din holds its value.
  - Latency is 1 cycle from the handshake edge to wr_en/din at the fifo.
  - At most one transfer per cycle; ack is one-hot or zero.
- Back-to-back:
  - Burst release and the next IDLE grant are consecutive cycles with no bubble.
  - Sustained throughput is 1 word/cycle while room=1.
- err_cnt increments each cycle fifo_wr_err=1 and saturates at 255. With correct room logic it should stay 0.
- reset asserted mid-burst:
  - All state is cleared immediately and fifo_wr_en drops asynchronously.
  - A word in its handshake cycle is not written.

Test Plan:
- Reset then single requester: req=4'b0001, data 32'hffff0000, fifo_data_count=0 -> ack[0]=1 same cycle; next cycle fifo_wr_en=1, fifo_din=ffff0000, busy=1, owner=0.
- Burst limit, BURST_LEN=4: req=4'b0011 constant with data 0000ffff/00ff00ff -> four writes from req0, then four from req1, alternating; ack never two-hot; fifo_wr_en high every cycle.
- Early release: req0 asserts for 2 words then drops, req2 waiting -> one bubble cycle with ack=0, then req2 is granted; rr_ptr=1, so req2 wins over req0 if req0 re-asserts.
- Full guard: fifo_data_count=7 with fifo_wr_en=1 -> ack=0 and no write issued; fifo_data_count falls to 6 with wr_en=0 -> ack resumes for the same owner; err_cnt stays 0.
- Fairness wrap: rr_ptr=3, req=4'b1001, BURST_LEN=1 -> grant order 3,0,3,0; owner wraps 3->0.
- Mid-burst reset: assert reset during the 2nd beat of a burst -> fifo_wr_en=0, busy=0, ack=0 immediately; after release, rr_ptr=0 and req=4'b1111 grants req0 first.
